// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw sensor lines and downstream ready in,
// coin code, occupancy and status flags out.
interface coin_acceptor_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic          coin5_raw;
   logic          coin10_raw;
   logic          en;
   logic [1:0]    coin;
   logic          coin_valid;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          reject;

   modport master (
      input  coin5_raw, coin10_raw, en,
      output coin, coin_valid, fifo_count,
      output overflow, reject
   );

   modport slave (
      output coin5_raw, coin10_raw, en,
      input  coin, coin_valid, fifo_count,
      input  overflow, reject
   );
endinterface

// File: rtl/coin_acceptor.sv
// Coin sensor front end: sync, debounce, edge-to-event, small FIFO,
// one registered coin code per enabled cycle.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input logic             clk,
   input logic             rst,
   coin_acceptor_if.master bus
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [1:0]            raw;
   logic [1:0]            meta;
   logic [1:0]            sync;
   logic [1:0]            filt;
   logic [1:0]            rise;
   logic [DW-1:0]         cnt [2];

   logic [FIFO_DEPTH-1:0] mem;
   logic [AW-1:0]         wptr;
   logic [AW-1:0]         rptr;
   logic [CW-1:0]         count;

   logic                  push_req;
   logic                  both;
   logic                  full;
   logic                  empty;
   logic                  pop;
   logic                  push;
   logic                  drop;

   logic [1:0]            coin_r;
   logic                  coin_valid_r;
   logic                  overflow_r;
   logic                  reject_r;

   // bit 0 = 5-unit channel, bit 1 = 10-unit channel
   assign raw = {bus.coin10_raw, bus.coin5_raw};

   always_comb begin
      rise = '0;
      for (int i = 0; i < 2; i++)
         rise[i] = sync[i] & ~filt[i] & (cnt[i] == DMAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '0;
         sync <= '0;
         filt <= '0;
         for (int i = 0; i < 2; i++)
            cnt[i] <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         for (int i = 0; i < 2; i++) begin
            if (sync[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DMAX) begin
               filt[i] <= sync[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + DW'(1);
            end
         end
      end
   end

   assign both     = rise[0] & rise[1];
   assign push_req = rise[0] ^ rise[1];
   assign full     = (count == FULL);
   assign empty    = (count == '0);
   assign pop      = bus.en & ~empty;
   // a pop frees the slot the simultaneous push lands in
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem          <= '0;
         wptr         <= '0;
         rptr         <= '0;
         count        <= '0;
         coin_r       <= 2'b00;
         coin_valid_r <= 1'b0;
         overflow_r   <= 1'b0;
         reject_r     <= 1'b0;
      end else begin
         reject_r     <= both;
         coin_valid_r <= pop;
         if (pop)
            coin_r <= mem[rptr] ? 2'b10 : 2'b01;
         else
            coin_r <= 2'b00;
         if (push) begin
            mem[wptr] <= rise[1];
            wptr      <= wptr + AW'(1);
         end
         if (pop)
            rptr <= rptr + AW'(1);
         if (drop)
            overflow_r <= 1'b1;
         if (push & ~pop)
            count <= count + CW'(1);
         else if (pop & ~push)
            count <= count - CW'(1);
      end
   end

   assign bus.coin       = coin_r;
   assign bus.coin_valid = coin_valid_r;
   assign bus.fifo_count = count;
   assign bus.overflow   = overflow_r;
   assign bus.reject     = reject_r;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_coin_acceptor;
   logic clk;
   logic rst;
   int   vec;
   int   errs;

   coin_acceptor_if #(.FIFO_DEPTH(4)) bus ();

   coin_acceptor #(
      .DEBOUNCE_CYCLES(4),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // clean coin: high long enough to debounce, then low long enough to settle
   task automatic put_coin(input bit is10);
      if (is10) bus.coin10_raw = 1'b1;
      else      bus.coin5_raw  = 1'b1;
      step(7);
      bus.coin5_raw  = 1'b0;
      bus.coin10_raw = 1'b0;
      step(7);
   endtask

   task automatic test_reset();
      rst            = 1'b0;
      bus.coin5_raw  = 1'b0;
      bus.coin10_raw = 1'b0;
      bus.en         = 1'b0;
      #3;
      vec++;
      if (bus.coin !== 2'b00 || bus.coin_valid !== 1'b0) begin
         errs++;
         $display("FAIL reset_coin: got %b/%b want 00/0",
                  bus.coin, bus.coin_valid);
      end
      vec++;
      if (bus.fifo_count !== 3'd0 || bus.overflow !== 1'b0 ||
          bus.reject !== 1'b0) begin
         errs++;
         $display("FAIL reset_flags: got cnt=%0d ovf=%b rej=%b want 0/0/0",
                  bus.fifo_count, bus.overflow, bus.reject);
      end
      #10;
      rst = 1'b1;
      step(2);
   endtask

   task automatic test_single_coin();
      bus.en        = 1'b1;
      bus.coin5_raw = 1'b1;
      step(6);
      vec++;
      if (bus.coin !== 2'b00 || bus.fifo_count !== 3'd1) begin
         errs++;
         $display("FAIL single_k5: got coin=%b cnt=%0d want 00/1",
                  bus.coin, bus.fifo_count);
      end
      step(1);
      vec++;
      if (bus.coin !== 2'b01 || bus.coin_valid !== 1'b1 ||
          bus.fifo_count !== 3'd0) begin
         errs++;
         $display("FAIL single_k6: got coin=%b v=%b cnt=%0d want 01/1/0",
                  bus.coin, bus.coin_valid, bus.fifo_count);
      end
      step(1);
      vec++;
      if (bus.coin !== 2'b00 || bus.coin_valid !== 1'b0) begin
         errs++;
         $display("FAIL single_k7: got coin=%b v=%b want 00/0",
                  bus.coin, bus.coin_valid);
      end
      bus.coin5_raw = 1'b0;
      step(8);
   endtask

   task automatic test_bounce();
      bit bad;
      bad = 1'b0;
      bus.en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.coin10_raw = 1'b1;
         step(1);
         bad |= (bus.coin !== 2'b00) || (bus.reject !== 1'b0);
         step(1);
         bad |= (bus.coin !== 2'b00) || (bus.reject !== 1'b0);
         bus.coin10_raw = 1'b0;
         step(1);
         bad |= (bus.coin !== 2'b00) || (bus.reject !== 1'b0);
         step(1);
         bad |= (bus.coin !== 2'b00) || (bus.reject !== 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         step(1);
         bad |= (bus.coin !== 2'b00) || (bus.reject !== 1'b0);
      end
      vec++;
      if (bad) begin
         errs++;
         $display("FAIL bounce_quiet: got coin/reject activity want none");
      end
      vec++;
      if (bus.fifo_count !== 3'd0 || bus.overflow !== 1'b0) begin
         errs++;
         $display("FAIL bounce_cnt: got cnt=%0d ovf=%b want 0/0",
                  bus.fifo_count, bus.overflow);
      end
   endtask

   task automatic test_simultaneous();
      bus.en         = 1'b1;
      bus.coin5_raw  = 1'b1;
      bus.coin10_raw = 1'b1;
      step(5);
      vec++;
      if (bus.reject !== 1'b0) begin
         errs++;
         $display("FAIL sim_early: got reject=%b want 0", bus.reject);
      end
      step(1);
      vec++;
      if (bus.reject !== 1'b1 || bus.fifo_count !== 3'd0) begin
         errs++;
         $display("FAIL sim_pulse: got rej=%b cnt=%0d want 1/0",
                  bus.reject, bus.fifo_count);
      end
      step(1);
      vec++;
      if (bus.reject !== 1'b0 || bus.coin !== 2'b00 ||
          bus.fifo_count !== 3'd0) begin
         errs++;
         $display("FAIL sim_after: got rej=%b coin=%b cnt=%0d want 0/00/0",
                  bus.reject, bus.coin, bus.fifo_count);
      end
      bus.coin5_raw  = 1'b0;
      bus.coin10_raw = 1'b0;
      step(8);
   endtask

   task automatic test_overflow();
      logic [1:0] exp_seq [5];
      exp_seq = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
      bus.en = 1'b0;
      put_coin(1'b0);
      put_coin(1'b1);
      put_coin(1'b1);
      put_coin(1'b0);
      vec++;
      if (bus.fifo_count !== 3'd4 || bus.overflow !== 1'b0 ||
          bus.coin !== 2'b00) begin
         errs++;
         $display("FAIL ovf_full: got cnt=%0d ovf=%b coin=%b want 4/0/00",
                  bus.fifo_count, bus.overflow, bus.coin);
      end
      put_coin(1'b1);
      vec++;
      if (bus.fifo_count !== 3'd4 || bus.overflow !== 1'b1) begin
         errs++;
         $display("FAIL ovf_drop: got cnt=%0d ovf=%b want 4/1",
                  bus.fifo_count, bus.overflow);
      end
      bus.en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         vec++;
         if (bus.coin !== exp_seq[i]) begin
            errs++;
            $display("FAIL ovf_drain[%0d]: got %b want %b",
                     i, bus.coin, exp_seq[i]);
         end
      end
      vec++;
      if (bus.fifo_count !== 3'd0 || bus.overflow !== 1'b1) begin
         errs++;
         $display("FAIL ovf_sticky: got cnt=%0d ovf=%b want 0/1",
                  bus.fifo_count, bus.overflow);
      end
   endtask

   task automatic test_async_reset();
      bit bad;
      bus.en = 1'b0;
      put_coin(1'b1);
      put_coin(1'b0);
      put_coin(1'b1);
      vec++;
      if (bus.fifo_count !== 3'd3) begin
         errs++;
         $display("FAIL ar_pre: got cnt=%0d want 3", bus.fifo_count);
      end
      #2;
      rst = 1'b0;
      #1;
      vec++;
      if (bus.fifo_count !== 3'd0 || bus.coin !== 2'b00 ||
          bus.overflow !== 1'b0) begin
         errs++;
         $display("FAIL ar_clear: got cnt=%0d coin=%b ovf=%b want 0/00/0",
                  bus.fifo_count, bus.coin, bus.overflow);
      end
      #3;
      rst = 1'b1;
      bus.en = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         bad |= (bus.coin !== 2'b00) || (bus.fifo_count !== 3'd0);
      end
      vec++;
      if (bad) begin
         errs++;
         $display("FAIL ar_stale: got coin/count activity after reset want none");
      end
   endtask

   task automatic test_full_push_pop();
      logic [1:0] exp_seq [6];
      exp_seq = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
      bus.en = 1'b0;
      put_coin(1'b1);
      put_coin(1'b0);
      put_coin(1'b0);
      put_coin(1'b0);
      bus.coin10_raw = 1'b1;
      step(5);
      vec++;
      if (bus.fifo_count !== 3'd4) begin
         errs++;
         $display("FAIL fpp_full: got cnt=%0d want 4", bus.fifo_count);
      end
      bus.en = 1'b1;
      step(1);
      vec++;
      if (bus.fifo_count !== 3'd4 || bus.overflow !== 1'b0 ||
          bus.coin !== exp_seq[0]) begin
         errs++;
         $display("FAIL fpp_edge: got cnt=%0d ovf=%b coin=%b want 4/0/10",
                  bus.fifo_count, bus.overflow, bus.coin);
      end
      for (int i = 1; i < 6; i++) begin
         step(1);
         vec++;
         if (bus.coin !== exp_seq[i]) begin
            errs++;
            $display("FAIL fpp_drain[%0d]: got %b want %b",
                     i, bus.coin, exp_seq[i]);
         end
      end
      vec++;
      if (bus.fifo_count !== 3'd0 || bus.overflow !== 1'b0) begin
         errs++;
         $display("FAIL fpp_end: got cnt=%0d ovf=%b want 0/0",
                  bus.fifo_count, bus.overflow);
      end
      bus.coin10_raw = 1'b0;
      step(8);
   endtask

   initial begin
      vec  = 0;
      errs = 0;
      test_reset();
      test_single_coin();
      test_bounce();
      test_simultaneous();
      test_overflow();
      test_async_reset();
      test_full_push_pop();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
